// File: rtl/renkon_layer_seq.sv
// Layer sequencer for the renkon convolution core: walks a host-written descriptor
// table and hands each layer's parameters to the core with a req / ack-low / ack-high handshake.
module renkon_layer_seq #(
  parameter int LAYERS   = 16,
  parameter int LAYERLOG = 4,
  parameter int LWIDTH   = 10,
  parameter int IMGSIZE  = 12,
  parameter int NETSIZE  = 11
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                cfg_we,
  input  logic [LAYERLOG-1:0] cfg_layer,
  input  logic [2:0]          cfg_field,
  input  logic [15:0]         cfg_data,
  input  logic                start,
  input  logic [LAYERLOG:0]   num_layers,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                aborted,
  output logic [LAYERLOG-1:0] cur_layer,
  output logic                core_req,
  input  logic                core_ack,
  output logic [LWIDTH-1:0]   core_total_out,
  output logic [LWIDTH-1:0]   core_total_in,
  output logic [LWIDTH-1:0]   core_img_size,
  output logic [LWIDTH-1:0]   core_fil_size,
  output logic [IMGSIZE-1:0]  core_input_addr,
  output logic [IMGSIZE-1:0]  core_output_addr,
  output logic [NETSIZE-1:0]  core_net_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_REQ, S_WAIT_LOW, S_WAIT_HIGH, S_DONE
  } state_t;

  localparam logic [LAYERLOG:0] MAX_NUM = LAYERS[LAYERLOG:0];

  state_t state;

  logic [LWIDTH-1:0]  tbl_total_out   [LAYERS];
  logic [LWIDTH-1:0]  tbl_total_in    [LAYERS];
  logic [LWIDTH-1:0]  tbl_img_size    [LAYERS];
  logic [LWIDTH-1:0]  tbl_fil_size    [LAYERS];
  logic [IMGSIZE-1:0] tbl_input_addr  [LAYERS];
  logic [IMGSIZE-1:0] tbl_output_addr [LAYERS];
  logic [NETSIZE-1:0] tbl_net_addr    [LAYERS];

  logic [LAYERLOG:0]  num_lat;
  logic [LAYERLOG:0]  last_idx;
  logic               abort_pend;
  logic               bad_p0;
  logic               start_ok;
  logic               abort_live;
  logic               is_last;
  logic               unused_cfg_hi;

  logic [LWIDTH-1:0]  rd_total_out;
  logic [LWIDTH-1:0]  rd_total_in;
  logic [LWIDTH-1:0]  rd_img_size;
  logic [LWIDTH-1:0]  rd_fil_size;

  // A descriptor the core cannot execute: empty filter, filter larger than
  // the image, or no input/output channels.
  function automatic logic desc_invalid(input logic [LWIDTH-1:0] tout,
                                        input logic [LWIDTH-1:0] tin,
                                        input logic [LWIDTH-1:0] img,
                                        input logic [LWIDTH-1:0] fil);
    return (fil == '0) || (fil > img) || (tin == '0) || (tout == '0);
  endfunction

  assign unused_cfg_hi = ^cfg_data[15:IMGSIZE];

  assign rd_total_out = tbl_total_out[cur_layer];
  assign rd_total_in  = tbl_total_in[cur_layer];
  assign rd_img_size  = tbl_img_size[cur_layer];
  assign rd_fil_size  = tbl_fil_size[cur_layer];

  assign start_ok   = core_ack && (num_layers != '0) && (num_layers <= MAX_NUM);
  assign last_idx   = num_lat - 1'b1;
  assign is_last    = ({1'b0, cur_layer} == last_idx);
  assign abort_live = abort && (state inside {S_LOAD, S_CHECK, S_REQ, S_WAIT_LOW, S_WAIT_HIGH});

  // Host writes land at the edge, so a LOAD in the same cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      case (cfg_field)
        3'd0:    tbl_total_out[cfg_layer]   <= cfg_data[LWIDTH-1:0];
        3'd1:    tbl_total_in[cfg_layer]    <= cfg_data[LWIDTH-1:0];
        3'd2:    tbl_img_size[cfg_layer]    <= cfg_data[LWIDTH-1:0];
        3'd3:    tbl_fil_size[cfg_layer]    <= cfg_data[LWIDTH-1:0];
        3'd4:    tbl_input_addr[cfg_layer]  <= cfg_data[IMGSIZE-1:0];
        3'd5:    tbl_output_addr[cfg_layer] <= cfg_data[IMGSIZE-1:0];
        3'd6:    tbl_net_addr[cfg_layer]    <= cfg_data[NETSIZE-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      aborted          <= 1'b0;
      cur_layer        <= '0;
      core_req         <= 1'b0;
      core_total_out   <= '0;
      core_total_in    <= '0;
      core_img_size    <= '0;
      core_fil_size    <= '0;
      core_input_addr  <= '0;
      core_output_addr <= '0;
      core_net_addr    <= '0;
      num_lat          <= '0;
      abort_pend       <= 1'b0;
      bad_p0           <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      core_req <= 1'b0;
      if (abort_live) begin
        abort_pend <= 1'b1;
        aborted    <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              num_lat    <= num_layers;
              cur_layer  <= '0;
              aborted    <= 1'b0;
              abort_pend <= 1'b0;
              busy       <= 1'b1;
              state      <= S_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        // Validity is evaluated alongside the load so err shows during CHECK.
        S_LOAD: begin
          core_total_out   <= rd_total_out;
          core_total_in    <= rd_total_in;
          core_img_size    <= rd_img_size;
          core_fil_size    <= rd_fil_size;
          core_input_addr  <= tbl_input_addr[cur_layer];
          core_output_addr <= tbl_output_addr[cur_layer];
          core_net_addr    <= tbl_net_addr[cur_layer];
          bad_p0 <= desc_invalid(rd_total_out, rd_total_in, rd_img_size, rd_fil_size);
          if (abort) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            err   <= desc_invalid(rd_total_out, rd_total_in, rd_img_size, rd_fil_size);
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (abort || bad_p0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            core_req <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT_LOW;
        S_WAIT_LOW: begin
          if (!core_ack) state <= S_WAIT_HIGH;
        end
        // Once the request is out, the layer always runs to ack-high before stopping.
        S_WAIT_HIGH: begin
          if (core_ack) begin
            if (is_last || abort_pend || abort) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cur_layer <= cur_layer + 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_renkon_layer_seq.sv
// Directed bench for renkon_layer_seq: descriptor vector table, start-rejection
// table and hand-written multi-layer, abort, reset and write-while-busy sequences.
module tb_renkon_layer_seq;

  logic        clk = 1'b0;
  logic        xrst;
  logic        cfg_we;
  logic [3:0]  cfg_layer;
  logic [2:0]  cfg_field;
  logic [15:0] cfg_data;
  logic        start;
  logic [4:0]  num_layers;
  logic        abort;
  logic        busy, done, err, aborted, core_req;
  logic        core_ack = 1'b1;
  logic [3:0]  cur_layer;
  logic [9:0]  core_total_out, core_total_in, core_img_size, core_fil_size;
  logic [11:0] core_input_addr, core_output_addr;
  logic [10:0] core_net_addr;

  renkon_layer_seq dut (
    .clk(clk), .xrst(xrst), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .start(start),
    .num_layers(num_layers), .abort(abort), .busy(busy), .done(done),
    .err(err), .aborted(aborted), .cur_layer(cur_layer), .core_req(core_req),
    .core_ack(core_ack), .core_total_out(core_total_out),
    .core_total_in(core_total_in), .core_img_size(core_img_size),
    .core_fil_size(core_fil_size), .core_input_addr(core_input_addr),
    .core_output_addr(core_output_addr), .core_net_addr(core_net_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] to, ti, img, fil, ia, oa, na;
    logic        ok;
  } desc_t;

  typedef struct {
    logic [4:0] num;
    logic       ack_low;
    logic       exp_err;
    logic       exp_busy;
  } rej_t;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, req_cnt = 0, done_cnt = 0, err_cnt = 0, rise_cnt = 0;
  int mcnt = -1, hold = 50;
  int done_cyc_last = 0, err_cyc_last = 0, start_cyc = 0;
  int req_cyc [256];
  int rise_cyc[256];
  logic [3:0] req_layer[256];
  logic [9:0] req_to   [256];
  logic force_low = 1'b0;
  logic prev_ack  = 1'b1;

  // Monitor plus core model: ack drops the cycle after req and stays low for 'hold' cycles.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (core_req) begin
      req_cyc[8'(req_cnt)]   = cyc;
      req_layer[8'(req_cnt)] = cur_layer;
      req_to[8'(req_cnt)]    = core_total_out;
      req_cnt = req_cnt + 1;
    end
    if (done) begin done_cnt = done_cnt + 1; done_cyc_last = cyc; end
    if (err)  begin err_cnt  = err_cnt + 1;  err_cyc_last  = cyc; end
    if (mcnt >= 0) begin
      mcnt = mcnt + 1;
      if (mcnt > hold) mcnt = -1;
    end
    if (core_req) mcnt = 0;
    core_ack = !(force_low || mcnt >= 1);
    if (core_ack && !prev_ack) begin
      rise_cyc[8'(rise_cnt)] = cyc;
      rise_cnt = rise_cnt + 1;
    end
    prev_ack = core_ack;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int l, input int f, input logic [15:0] d);
    cfg_we = 1'b1; cfg_layer = 4'(l); cfg_field = 3'(f); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic prog(input int l, input desc_t d);
    wr(l, 0, d.to); wr(l, 1, d.ti); wr(l, 2, d.img); wr(l, 3, d.fil);
    wr(l, 4, d.ia); wr(l, 5, d.oa); wr(l, 6, d.na);
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_layers = 5'(n); start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int i = 0;
    while (done_cnt == d0 && i < 2000) begin tick(); i++; end
    chk({name, "_timeout"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_req(input int target, input string name);
    int i = 0;
    while (req_cnt < target && i < 2000) begin tick(); i++; end
    chk({name, "_timeout"}, 32'(req_cnt >= target), 32'd1);
  endtask

  function automatic desc_t mk(input int to, input int ti, input int img, input int fil);
    desc_t d;
    d.to = 16'(to); d.ti = 16'(ti); d.img = 16'(img); d.fil = 16'(fil);
    d.ia = 16'h0100; d.oa = 16'h0200; d.na = 16'h0040; d.ok = 1'b1;
    return d;
  endfunction

  desc_t vec[7];
  rej_t  rej[6];
  int r0, d0, e0, a0;
  logic busy_seen;

  initial begin
    vec[0] = '{16'd8,     16'd2,     16'd12,    16'd5,     16'h0000, 16'h0400, 16'h0010, 1'b1};
    vec[1] = '{16'd1,     16'd1,     16'd1,     16'd1,     16'h0FFF, 16'h0001, 16'h07FF, 1'b1};
    vec[2] = '{16'd4,     16'd3,     16'd10,    16'd0,     16'h0010, 16'h0020, 16'h0030, 1'b0};
    vec[3] = '{16'd4,     16'd3,     16'd10,    16'd11,    16'h0011, 16'h0021, 16'h0031, 1'b0};
    vec[4] = '{16'd4,     16'd0,     16'd10,    16'd3,     16'h0012, 16'h0022, 16'h0032, 1'b0};
    vec[5] = '{16'h0400,  16'd3,     16'd10,    16'd3,     16'h0013, 16'h0023, 16'h0033, 1'b0};
    vec[6] = '{16'hFFFF,  16'h03FF,  16'h83FF,  16'h03FF,  16'hF123, 16'h0456, 16'hFBAB, 1'b1};

    rej[0] = '{5'd0,  1'b0, 1'b1, 1'b0};
    rej[1] = '{5'd17, 1'b0, 1'b1, 1'b0};
    rej[2] = '{5'd31, 1'b0, 1'b1, 1'b0};
    rej[3] = '{5'd1,  1'b1, 1'b1, 1'b0};
    rej[4] = '{5'd16, 1'b1, 1'b1, 1'b0};
    rej[5] = '{5'd1,  1'b0, 1'b0, 1'b1};

    xrst = 1'b1; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0;
    start = 1'b0; num_layers = '0; abort = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_req", 32'(core_req), 32'd0);
    chk("rst_cur_layer", 32'(cur_layer), 32'd0);
    chk("rst_total_out", 32'(core_total_out), 32'd0);
    chk("rst_net_addr", 32'(core_net_addr), 32'd0);
    xrst = 1'b0;
    tick();

    abort = 1'b1; tick(); abort = 1'b0; tick();
    chk("idle_abort_ignored", 32'(aborted), 32'd0);
    chk("idle_abort_busy", 32'(busy), 32'd0);

    // Single-layer descriptor vectors.
    for (int v = 0; v < 7; v++) begin
      hold = (v == 0) ? 50 : 4;
      prog(0, vec[v]);
      r0 = req_cnt; d0 = done_cnt; e0 = err_cnt; a0 = rise_cnt;
      do_start(1);
      chk("vec_busy_up", 32'(busy), 32'd1);
      wait_done(d0, "vec_done");
      chk("vec_req_count", 32'(req_cnt - r0), 32'(vec[v].ok));
      chk("vec_err_count", 32'(err_cnt - e0), 32'(!vec[v].ok));
      chk("vec_total_out", 32'(core_total_out), 32'(vec[v].to & 16'h03FF));
      chk("vec_total_in", 32'(core_total_in), 32'(vec[v].ti & 16'h03FF));
      chk("vec_img_size", 32'(core_img_size), 32'(vec[v].img & 16'h03FF));
      chk("vec_fil_size", 32'(core_fil_size), 32'(vec[v].fil & 16'h03FF));
      chk("vec_input_addr", 32'(core_input_addr), 32'(vec[v].ia & 16'h0FFF));
      chk("vec_output_addr", 32'(core_output_addr), 32'(vec[v].oa & 16'h0FFF));
      chk("vec_net_addr", 32'(core_net_addr), 32'(vec[v].na & 16'h07FF));
      if (vec[v].ok) begin
        chk("vec_req_latency", 32'(req_cyc[8'(r0)] - start_cyc), 32'd3);
        chk("vec_done_after_ack", 32'(done_cyc_last - rise_cyc[8'(a0)]), 32'd1);
      end else begin
        chk("vec_done_after_err", 32'(done_cyc_last - err_cyc_last), 32'd1);
      end
      chk("vec_busy_in_done", 32'(busy), 32'd1);
      tick();
      chk("vec_done_one_cycle", 32'(done), 32'd0);
      chk("vec_busy_low", 32'(busy), 32'd0);
    end

    // Start acceptance table.
    hold = 4;
    for (int v = 0; v < 6; v++) begin
      if (rej[v].ack_low) begin force_low = 1'b1; tick(); end
      e0 = err_cnt; d0 = done_cnt;
      do_start(int'(rej[v].num));
      force_low = 1'b0;
      busy_seen = busy;
      tick(); busy_seen = busy_seen | busy;
      tick(); busy_seen = busy_seen | busy;
      chk("rej_err", 32'(err_cnt - e0), 32'(rej[v].exp_err));
      chk("rej_busy", 32'(busy_seen), 32'(rej[v].exp_busy));
      if (rej[v].exp_busy) wait_done(d0, "rej_run");
      repeat (3) tick();
    end

    // Three layers: back-to-back turnaround and cur_layer sequencing.
    hold = 6;
    prog(0, mk(11, 1, 8, 3));
    prog(1, mk(22, 2, 9, 9));
    prog(2, mk(33, 3, 10, 1));
    r0 = req_cnt; d0 = done_cnt; a0 = rise_cnt;
    do_start(3);
    wait_done(d0, "three_done");
    chk("three_req_count", 32'(req_cnt - r0), 32'd3);
    chk("three_done_count", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("three_cur_layer", 32'(req_layer[8'(r0 + i)]), 32'(i));
      chk("three_total_out", 32'(req_to[8'(r0 + i)]), 32'(11 * (i + 1)));
      if (i == 0) chk("three_first_req", 32'(req_cyc[8'(r0)] - start_cyc), 32'd3);
      else chk("three_turnaround", 32'(req_cyc[8'(r0 + i)] - rise_cyc[8'(a0 + i - 1)]), 32'd3);
    end
    chk("three_done_after_ack", 32'(done_cyc_last - rise_cyc[8'(a0 + 2)]), 32'd1);
    tick();
    chk("three_busy_low", 32'(busy), 32'd0);

    // Invalid descriptor on layer 1.
    prog(1, mk(5, 5, 12, 13));
    r0 = req_cnt; d0 = done_cnt; e0 = err_cnt; a0 = rise_cnt;
    do_start(2);
    wait_done(d0, "inv_done");
    chk("inv_req_count", 32'(req_cnt - r0), 32'd1);
    chk("inv_err_count", 32'(err_cnt - e0), 32'd1);
    chk("inv_err_in_check", 32'(err_cyc_last - rise_cyc[8'(a0)]), 32'd2);
    chk("inv_done_after_err", 32'(done_cyc_last - err_cyc_last), 32'd1);
    chk("inv_cur_layer", 32'(cur_layer), 32'd1);
    repeat (2) tick();

    // Abort in layer 0 WAIT_HIGH with four layers requested.
    hold = 10;
    prog(1, mk(22, 2, 9, 9));
    prog(3, mk(44, 4, 6, 2));
    r0 = req_cnt; d0 = done_cnt; e0 = err_cnt;
    do_start(4);
    wait_req(r0 + 1, "abort_req");
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    wait_done(d0, "abort_done");
    chk("abort_req_count", 32'(req_cnt - r0), 32'd1);
    chk("abort_err_count", 32'(err_cnt - e0), 32'd0);
    chk("abort_cur_layer", 32'(cur_layer), 32'd0);
    chk("abort_flag", 32'(aborted), 32'd1);
    repeat (3) tick();
    do_start(0);
    tick();
    chk("abort_sticky_rejected", 32'(aborted), 32'd1);

    // Abort sampled in LOAD: no request, straight to done.
    r0 = req_cnt; d0 = done_cnt;
    do_start(2);
    chk("load_abort_cleared", 32'(aborted), 32'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    wait_done(d0, "load_abort_done");
    chk("load_abort_no_req", 32'(req_cnt - r0), 32'd0);
    chk("load_abort_flag", 32'(aborted), 32'd1);
    repeat (2) tick();

    // Write layer 2 while layer 1 is in flight.
    hold = 12;
    r0 = req_cnt; d0 = done_cnt;
    do_start(3);
    chk("wwb_aborted_cleared", 32'(aborted), 32'd0);
    wait_req(r0 + 2, "wwb_req1");
    wr(2, 0, 16'd77);
    wait_done(d0, "wwb_done");
    chk("wwb_req_count", 32'(req_cnt - r0), 32'd3);
    chk("wwb_layer2_idx", 32'(req_layer[8'(r0 + 2)]), 32'd2);
    chk("wwb_layer2_total_out", 32'(req_to[8'(r0 + 2)]), 32'd77);
    repeat (2) tick();

    // Reset while the layer is in WAIT_LOW.
    hold = 20;
    r0 = req_cnt; d0 = done_cnt;
    do_start(1);
    wait_req(r0 + 1, "rst_run_req");
    tick();
    xrst = 1'b1; tick(); xrst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_req", 32'(core_req), 32'd0);
    chk("midrst_cur_layer", 32'(cur_layer), 32'd0);
    chk("midrst_total_out", 32'(core_total_out), 32'd0);
    chk("midrst_input_addr", 32'(core_input_addr), 32'd0);
    chk("midrst_output_addr", 32'(core_output_addr), 32'd0);
    chk("midrst_net_addr", 32'(core_net_addr), 32'd0);
    repeat (25) tick();
    chk("midrst_stays_idle", 32'(busy), 32'd0);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    // The table survives reset.
    hold = 4;
    r0 = req_cnt; d0 = done_cnt;
    do_start(1);
    wait_done(d0, "post_rst_done");
    chk("post_rst_req", 32'(req_cnt - r0), 32'd1);
    chk("post_rst_total_out", 32'(core_total_out), 32'd11);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
